wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
- Parametrised successor to the single-lane writeback stage: retires up to NLANES instructions per cycle into the architectural register file.
- Keeps 64-bit clock and retired-instruction counters and raises a halt request at a programmable retire limit.
- Pushes every retired instruction into a trace FIFO, drained by a valid/ready debug consumer.
- Sits at the end of the pipeline, after memory/execute; feeds the register file back to decode.

Parameters:
XLEN, 32, data/PC width
NLANES, 2, commit lanes per cycle (1..4); lane 0 is oldest
TRACE_DEPTH, 8, trace FIFO entries; power of two, >= NLANES
REG_INIT, all-ones XLEN, reset value of x1..x31 (x0 is always 0)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
lane_valid  in  NLANES  lane i retires this cycle
lane_pc  in  NLANES*XLEN  PC per lane
lane_rf_wen  in  NLANES  lane writes rd
lane_rd  in  NLANES*5  destination register
lane_wdata  in  NLANES*XLEN  write data
end_inst_count  in  64  halt limit; 0 disables
regfile  out  32*XLEN  architectural registers, registered
clock_count  out  64  cycles since reset release
inst_count  out  64  retired instructions
halt_req  out  1  sticky halt request
trace_valid  out  1  FIFO head valid
trace_ready  in  1  consumer accepts head
trace_pc  out  XLEN  head PC
trace_rd  out  5  head rd; 0 if no write
trace_wdata  out  XLEN  head data; 0 if no write
trace_overflow  out  1  sticky: a trace entry was dropped
trace_drop_count  out  32  dropped entries, saturating

Behaviour:
- Reset (async assert, sync to clk on release):
  - regfile[0]=0, regfile[1..31]=REG_INIT.
  - All counters 0; halt_req=0.
  - FIFO empty: trace_valid=0, trace_overflow=0, trace_drop_count=0.
- Register write: lane i writes when lane_valid[i] & lane_rf_wen[i] & lane_rd[i]!=0. Visible on regfile the cycle after the edge (1-cycle latency).
- Same rd from several lanes in one cycle: highest-index (youngest) lane wins.
- x0 is never written; it reads 0 at all times.
- clock_count increments every cycle out of reset.
- inst_count += popcount(lane_valid) per cycle; wraps mod 2^64.
- halt_req sets on the cycle after inst_count's registered value becomes >= end_inst_count, with end_inst_count!=0. It stays set until reset.
- Commit inputs are not gated by halt_req; the upstream pipeline stalls.
- Trace push: each lane with lane_valid forms one entry {pc, rd|0, wdata|0}; pushes are in lane order.
- free = DEPTH - occupancy + (trace_valid & trace_ready). A pop frees its slot in the same cycle.
- If valid lanes exceed free slots:
  - push the lowest-index lanes that fit and drop the rest;
  - set trace_overflow;
  - add the number dropped to trace_drop_count, saturating at 2^32-1.
- A pop occurs on trace_valid & trace_ready. Head data is stable while trace_valid & !trace_ready.
- A pushed entry is visible at the head no earlier than the next cycle; there is no bypass.
- Pointers: log2(DEPTH)-bit, wrap naturally. Occupancy counter is log2(DEPTH)+1 bits. Full means occupancy==DEPTH.
- Reset asserted mid-operation discards FIFO contents and counters immediately (async).
- Simulation-only checks (XZSTOP define):
  - X/Z on any written wdata bit prints the lane PC and calls the finish macro.
  - With PRINT_DEBUGINFO, log valid, pc, rd, data and inst_count per retiring lane in "data,wbcommit.<field>,<fmt>,<val>" format.

Decomposition:
- Shared package: UIntX, UInt5, UInt64 typedefs; trace_entry_t struct {pc, rd, wdata}; REG_INIT default constant.
- Sub-module trace_fifo_mw: multi-write (NLANES pushes), single-read, parametrised by DEPTH/NLANES/entry type; outputs free count and accepted-push count.
- Register-file write merge and counters stay in wb_commit_unit.

Test Plan:
- Reset release -> x1=REG_INIT, x0=0, counters 0, trace_valid=0; after 5 idle cycles clock_count=5, inst_count=0.
- Lane0 {rd=5, data=0x11}, lane1 {rd=5, data=0x22}, both valid, same cycle -> next cycle x5=0x22; inst_count+=2; trace pops in order pc0 then pc1.
- lane_rd=0, rf_wen=1, data=0xDEAD -> x0 stays 0; trace entry has rd=0, wdata=0; inst_count+=1.
- DEPTH=8, trace_ready=0, 5 cycles of 2 valid lanes -> 8 entries stored; trace_drop_count=2, overflow=1. Then a cycle with ready=1 and 2 pushes -> 1 accepted, drop_count=3.
- end_inst_count=3, retire 2 then 2 -> halt_req rises the cycle after inst_count=4 and stays high; end_inst_count=0 -> never rises.
- Assert reset mid-burst with FIFO holding 4 entries -> trace_valid drops without waiting for a clock edge; registers return to REG_INIT; counters 0.

Source files
------------

// File: rtl/wb_commit_unit_pkg.sv
// Shared types for the multi-lane writeback/commit stage and its trace FIFO.
package wb_commit_unit_pkg;

   localparam int XLEN_DEF = 32;

   typedef logic [XLEN_DEF-1:0] UIntX;
   typedef logic [4:0]          UInt5;
   typedef logic [63:0]         UInt64;

   typedef struct packed {
      UIntX pc;
      UInt5 rd;
      UIntX wdata;
   } trace_entry_t;

   localparam UIntX REG_INIT_DEF = '1;

endpackage

// File: rtl/wb_commit_unit_if.sv
// Commit-lane inputs and trace-port handshake of the commit unit.
interface wb_commit_unit_if #(
   parameter int XLEN   = 32,
   parameter int NLANES = 2
);
   logic [NLANES-1:0]      lane_valid;
   logic [NLANES*XLEN-1:0] lane_pc;
   logic [NLANES-1:0]      lane_rf_wen;
   logic [NLANES*5-1:0]    lane_rd;
   logic [NLANES*XLEN-1:0] lane_wdata;

   logic                   trace_valid;
   logic                   trace_ready;
   logic [XLEN-1:0]        trace_pc;
   logic [4:0]             trace_rd;
   logic [XLEN-1:0]        trace_wdata;

   modport master (
      output lane_valid, lane_pc, lane_rf_wen, lane_rd, lane_wdata, trace_ready,
      input  trace_valid, trace_pc, trace_rd, trace_wdata
   );

   modport slave (
      input  lane_valid, lane_pc, lane_rf_wen, lane_rd, lane_wdata, trace_ready,
      output trace_valid, trace_pc, trace_rd, trace_wdata
   );
endinterface

// File: rtl/wb_commit_unit_trace_fifo_mw.sv
// Multi-write, single-read FIFO: up to NLANES pushes per cycle in lane order,
// one pop per cycle; lanes beyond the free space are refused.
module trace_fifo_mw
   import wb_commit_unit_pkg::*;
#(
   parameter int  DEPTH   = 8,
   parameter int  NLANES  = 2,
   parameter type entry_t = trace_entry_t,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NLANES-1:0] push_valid,
   input  entry_t            push_data [NLANES],
   output logic              head_valid,
   input  logic              head_ready,
   output entry_t            head_data,
   output logic [AW:0]       free_count,
   output logic [AW:0]       accepted
);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   entry_t            mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       occ;
   logic              pop;
   logic [NLANES-1:0] wr_en;
   logic [AW-1:0]     wr_idx [NLANES];
   logic [AW:0]       slot;

   assign head_valid = (occ != '0);
   assign pop        = head_valid & head_ready;
   assign head_data  = mem[rd_ptr];
   // A pop this cycle frees its slot for this cycle's pushes.
   assign free_count = DEPTH_C - occ + (AW+1)'(pop);

   always_comb begin
      slot   = '0;
      wr_en  = '0;
      wr_idx = '{default: '0};
      for (int i = 0; i < NLANES; i++) begin
         wr_idx[i] = wr_ptr + slot[AW-1:0];
         if (push_valid[i] && (slot < free_count)) begin
            wr_en[i] = 1'b1;
            slot     = slot + (AW+1)'(1);
         end
      end
      accepted = slot;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         wr_ptr <= wr_ptr + accepted[AW-1:0];
         rd_ptr <= rd_ptr + AW'(pop);
         occ    <= occ + accepted - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NLANES; i++) begin
         if (wr_en[i]) mem[wr_idx[i]] <= push_data[i];
      end
   end

endmodule

// File: rtl/wb_commit_unit.sv
// Multi-lane commit stage: merges lane writes into the register file, keeps
// cycle/retire counters with a halt limit, and traces every retired lane.
module wb_commit_unit
   import wb_commit_unit_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              NLANES      = 2,
   parameter int              TRACE_DEPTH = 8,
   parameter logic [XLEN-1:0] REG_INIT    = {XLEN{1'b1}}
) (
   input  logic               clk,
   input  logic               reset,
   wb_commit_unit_if.slave    bus,
   input  UInt64              end_inst_count,
   output logic [32*XLEN-1:0] regfile,
   output UInt64              clock_count,
   output UInt64              inst_count,
   output logic               halt_req,
   output logic               trace_overflow,
   output logic [31:0]        trace_drop_count
);
   localparam int AW = $clog2(TRACE_DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      UInt5            rd;
      logic [XLEN-1:0] wdata;
   } lane_entry_t;

   logic [XLEN-1:0]   lane_pc    [NLANES];
   logic [XLEN-1:0]   lane_wdata [NLANES];
   UInt5              lane_rd    [NLANES];
   logic [NLANES-1:0] lane_wen;
   lane_entry_t       push_data  [NLANES];
   lane_entry_t       head;
   logic              head_valid;
   logic [AW:0]       free_count;
   logic [AW:0]       accepted;
   logic [AW:0]       n_valid;
   logic [AW:0]       n_drop;
   logic [XLEN-1:0]   rf_q [32];

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      assign lane_pc[i]    = bus.lane_pc[i*XLEN +: XLEN];
      assign lane_wdata[i] = bus.lane_wdata[i*XLEN +: XLEN];
      assign lane_rd[i]    = bus.lane_rd[i*5 +: 5];
      assign lane_wen[i]   = bus.lane_valid[i] & bus.lane_rf_wen[i] & (lane_rd[i] != 5'd0);
      assign push_data[i]  = '{pc:    lane_pc[i],
                               rd:    lane_wen[i] ? lane_rd[i] : 5'd0,
                               wdata: lane_wen[i] ? lane_wdata[i] : '0};
   end

   always_comb begin
      n_valid = '0;
      for (int i = 0; i < NLANES; i++) n_valid = n_valid + (AW+1)'(bus.lane_valid[i]);
      n_drop = n_valid - accepted;
   end

   trace_fifo_mw #(
      .DEPTH   (TRACE_DEPTH),
      .NLANES  (NLANES),
      .entry_t (lane_entry_t)
   ) u_trace (
      .clk        (clk),
      .reset      (reset),
      .push_valid (bus.lane_valid),
      .push_data  (push_data),
      .head_valid (head_valid),
      .head_ready (bus.trace_ready),
      .head_data  (head),
      .free_count (free_count),
      .accepted   (accepted)
   );

   assign bus.trace_valid = head_valid;
   assign bus.trace_pc    = head.pc;
   assign bus.trace_rd    = head.rd;
   assign bus.trace_wdata = head.wdata;

   // Lanes are applied oldest first so the youngest write to a shared rd lands last.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_q[0] <= '0;
         for (int j = 1; j < 32; j++) rf_q[j] <= REG_INIT;
      end else begin
         for (int i = 0; i < NLANES; i++) begin
            if (lane_wen[i]) rf_q[lane_rd[i]] <= lane_wdata[i];
         end
      end
   end

   for (genvar j = 0; j < 32; j++) begin : g_rf
      assign regfile[j*XLEN +: XLEN] = rf_q[j];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clock_count      <= '0;
         inst_count       <= '0;
         halt_req         <= 1'b0;
         trace_overflow   <= 1'b0;
         trace_drop_count <= '0;
      end else begin
         clock_count      <= clock_count + 64'd1;
         inst_count       <= inst_count + 64'(n_valid);
         if ((end_inst_count != '0) && (inst_count >= end_inst_count)) halt_req <= 1'b1;
         if (n_valid > free_count) trace_overflow <= 1'b1;
         trace_drop_count <= sat_add32(trace_drop_count, 32'(n_drop));
      end
   end

`ifdef XZSTOP
`ifndef WB_FINISH
`define WB_FINISH $finish
`endif
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NLANES; i++) begin
            if (lane_wen[i] && $isunknown(lane_wdata[i])) begin
               $display("wbcommit: X/Z write data at pc %h", lane_pc[i]);
               `WB_FINISH;
            end
`ifdef PRINT_DEBUGINFO
            if (bus.lane_valid[i]) begin
               $display("data,wbcommit.valid,%%d,%0d", bus.lane_valid[i]);
               $display("data,wbcommit.pc,%%x,%h", lane_pc[i]);
               $display("data,wbcommit.rd,%%d,%0d", push_data[i].rd);
               $display("data,wbcommit.data,%%x,%h", push_data[i].wdata);
               $display("data,wbcommit.inst_count,%%d,%0d", inst_count);
            end
`endif
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit; trace output is checked by a scoreboard monitor.
module tb_wb_commit_unit;
   import wb_commit_unit_pkg::*;

   localparam int XLEN   = 32;
   localparam int NLANES = 2;
   localparam int DEPTH  = 8;

   logic               clk = 1'b0;
   logic               reset;
   UInt64              end_inst_count;
   logic [32*XLEN-1:0] regfile;
   UInt64              clock_count;
   UInt64              inst_count;
   logic               halt_req;
   logic               trace_overflow;
   logic [31:0]        trace_drop_count;

   int                 n_checks = 0;
   int                 n_fail   = 0;
   trace_entry_t       exp_q [$];
   trace_entry_t       mon_e;

   wb_commit_unit_if #(.XLEN(XLEN), .NLANES(NLANES)) bus ();

   wb_commit_unit #(
      .XLEN        (XLEN),
      .NLANES      (NLANES),
      .TRACE_DEPTH (DEPTH),
      .REG_INIT    (REG_INIT_DEF)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus),
      .end_inst_count   (end_inst_count),
      .regfile          (regfile),
      .clock_count      (clock_count),
      .inst_count       (inst_count),
      .halt_req         (halt_req),
      .trace_overflow   (trace_overflow),
      .trace_drop_count (trace_drop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] xreg(input int r);
      return 64'(regfile[r*XLEN +: XLEN]);
   endfunction

   function automatic trace_entry_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [31:0] d, input logic w);
      logic wr;
      wr = w && (rd != 5'd0);
      return '{pc: pc, rd: wr ? rd : 5'd0, wdata: wr ? d : 32'd0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one commit cycle; acc marks lanes expected to reach the trace FIFO.
   task automatic lanes(input logic [1:0] v, input logic [1:0] wen,
                        input logic [4:0] rd0, input logic [4:0] rd1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic [1:0] acc);
      bus.lane_valid  = v;
      bus.lane_rf_wen = wen;
      bus.lane_rd     = {rd1, rd0};
      bus.lane_wdata  = {d1, d0};
      bus.lane_pc     = {pc1, pc0};
      if (acc[0]) exp_q.push_back(mk(pc0, rd0, d0, wen[0]));
      if (acc[1]) exp_q.push_back(mk(pc1, rd1, d1, wen[1]));
      @(posedge clk);
      #1;
      bus.lane_valid  = '0;
   endtask

   always @(negedge clk) begin
      if (!reset && bus.trace_valid && bus.trace_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL trace_unexpected: got pc=0x%0h rd=%0d data=0x%0h, expected no entry",
                     bus.trace_pc, bus.trace_rd, bus.trace_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.trace_pc !== mon_e.pc || bus.trace_rd !== mon_e.rd ||
                bus.trace_wdata !== mon_e.wdata) begin
               n_fail++;
               $display("FAIL trace_entry: got pc=0x%0h rd=%0d data=0x%0h, expected pc=0x%0h rd=%0d data=0x%0h",
                        bus.trace_pc, bus.trace_rd, bus.trace_wdata, mon_e.pc, mon_e.rd, mon_e.wdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset           = 1'b1;
      end_inst_count  = '0;
      bus.lane_valid  = '0;
      bus.lane_rf_wen = '0;
      bus.lane_rd     = '0;
      bus.lane_wdata  = '0;
      bus.lane_pc     = '0;
      bus.trace_ready = 1'b1;
      idle(2);

      check("rst_x0", xreg(0), 64'h0);
      check("rst_x1", xreg(1), 64'(REG_INIT_DEF));
      check("rst_x31", xreg(31), 64'(REG_INIT_DEF));
      check("rst_clock_count", clock_count, 64'h0);
      check("rst_inst_count", inst_count, 64'h0);
      check("rst_trace_valid", 64'(bus.trace_valid), 64'h0);
      check("rst_halt", 64'(halt_req), 64'h0);
      check("rst_overflow", 64'(trace_overflow), 64'h0);
      check("rst_drop_count", 64'(trace_drop_count), 64'h0);

      reset = 1'b0;
      idle(5);
      check("idle_clock_count", clock_count, 64'd5);
      check("idle_inst_count", inst_count, 64'd0);

      lanes(2'b11, 2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 32'h100, 32'h104, 2'b11);
      check("same_rd_youngest", xreg(5), 64'h22);
      check("same_rd_inst_count", inst_count, 64'd2);
      check("trace_valid_after_push", 64'(bus.trace_valid), 64'h1);

      lanes(2'b01, 2'b01, 5'd0, 5'd0, 32'hDEAD, 32'h0, 32'h200, 32'h0, 2'b01);
      check("x0_stays_zero", xreg(0), 64'h0);
      check("x0_inst_count", inst_count, 64'd3);

      lanes(2'b10, 2'b00, 5'd0, 5'd7, 32'h0, 32'hBEEF, 32'h0, 32'h204, 2'b10);
      check("no_wen_x7", xreg(7), 64'(REG_INIT_DEF));
      check("no_wen_inst_count", inst_count, 64'd4);

      idle(4);
      check("drained_trace_valid", 64'(bus.trace_valid), 64'h0);

      bus.trace_ready = 1'b0;
      for (int c = 0; c < 4; c++)
         lanes(2'b11, 2'b11, 5'(10 + 2*c), 5'(11 + 2*c), 32'(32'h1000 + 2*c), 32'(32'h1001 + 2*c),
               32'(32'h300 + 8*c), 32'(32'h304 + 8*c), 2'b11);
      check("full_no_drop", 64'(trace_drop_count), 64'h0);
      check("full_no_overflow", 64'(trace_overflow), 64'h0);
      lanes(2'b11, 2'b11, 5'd18, 5'd19, 32'h1008, 32'h1009, 32'h320, 32'h324, 2'b00);
      check("ovf_drop_count", 64'(trace_drop_count), 64'd2);
      check("ovf_flag", 64'(trace_overflow), 64'h1);
      check("ovf_regfile_x19", xreg(19), 64'h1009);
      check("ovf_trace_valid", 64'(bus.trace_valid), 64'h1);

      bus.trace_ready = 1'b1;
      lanes(2'b11, 2'b11, 5'd20, 5'd21, 32'h100A, 32'h100B, 32'h328, 32'h32C, 2'b01);
      check("pop_push_drop_count", 64'(trace_drop_count), 64'd3);
      check("pop_push_x21", xreg(21), 64'h100B);
      idle(12);
      check("ovf_drained", 64'(bus.trace_valid), 64'h0);
      check("limit0_inst_count", inst_count, 64'd16);
      check("limit0_no_halt", 64'(halt_req), 64'h0);

      bus.trace_ready = 1'b0;
      lanes(2'b11, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 32'h400, 32'h404, 2'b00);
      lanes(2'b11, 2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 32'h408, 32'h40C, 2'b00);
      check("pre_reset_trace_valid", 64'(bus.trace_valid), 64'h1);
      check("pre_reset_x3", xreg(3), 64'h33);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_trace_valid", 64'(bus.trace_valid), 64'h0);
      check("async_rst_x3", xreg(3), 64'(REG_INIT_DEF));
      check("async_rst_clock_count", clock_count, 64'h0);
      check("async_rst_inst_count", inst_count, 64'h0);
      check("async_rst_drop_count", 64'(trace_drop_count), 64'h0);
      check("async_rst_overflow", 64'(trace_overflow), 64'h0);

      end_inst_count  = 64'd3;
      bus.trace_ready = 1'b1;
      idle(1);
      reset = 1'b0;
      lanes(2'b11, 2'b00, 5'd1, 5'd2, 32'h0, 32'h0, 32'h500, 32'h504, 2'b11);
      check("halt_inst_2", inst_count, 64'd2);
      check("halt_low_at_2", 64'(halt_req), 64'h0);
      lanes(2'b11, 2'b00, 5'd1, 5'd2, 32'h0, 32'h0, 32'h508, 32'h50C, 2'b11);
      check("halt_inst_4", inst_count, 64'd4);
      check("halt_low_same_cycle", 64'(halt_req), 64'h0);
      idle(1);
      check("halt_rises", 64'(halt_req), 64'h1);
      idle(3);
      check("halt_sticky", 64'(halt_req), 64'h1);

      idle(4);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
